// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with full-image debounce and a
// press-event FIFO. Rows are driven one at a time (active-low), columns are
// synchronized and sampled at the end of each row slot, and a full 16-key
// snapshot must repeat for DEBOUNCE_SCANS scans before key_state follows it.
// Newly pressed keys are queued lowest index first.
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        RST,
  output logic [3:0]  row_o,
  input  logic [3:0]  col_i,
  output logic [15:0] key_state,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ready
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STB_W  = 4;

  // Column synchronizer and scan position
  logic [3:0]        col_s1;
  logic [3:0]        col_s2;
  logic [SLOT_W-1:0] slot;
  logic [1:0]        row;

  // Debounce state
  logic [15:0]      snapshot;
  logic [15:0]      prev_snap;
  logic             scanned;
  logic [STB_W-1:0] stable_cnt;
  logic [15:0]      pending;

  // Event FIFO
  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Combinational next-state values
  logic             slot_end;
  logic             scan_end;
  logic [1:0]       row_next;
  logic [3:0]       pressed;
  logic [15:0]      snap_new;
  logic [STB_W-1:0] stable_new;
  logic             commit;
  logic [15:0]      rising;
  logic             pop;
  logic             push;
  logic [3:0]       push_idx;
  logic [15:0]      clr;
  logic [15:0]      pending_next;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_next;
  logic [3:0]       code_next;

  // Scan timing, snapshot capture and end-of-scan debounce decision
  always_comb begin
    slot_end   = (slot == SLOT_W'(SCAN_DIV - 1));
    scan_end   = slot_end && (row == 2'd3);
    row_next   = slot_end ? row + 2'd1 : row;
    pressed    = ~col_s2;
    snap_new   = snapshot;
    stable_new = stable_cnt;
    if (slot_end) begin
      snap_new[{row, 2'b00} +: 4] = pressed;
    end
    if (scan_end) begin
      if (!scanned || (snap_new != prev_snap)) begin
        stable_new = STB_W'(1);
      end else if (stable_cnt < STB_W'(DEBOUNCE_SCANS)) begin
        stable_new = stable_cnt + STB_W'(1);
      end
    end
    commit = scan_end && (stable_new == STB_W'(DEBOUNCE_SCANS)) && (snap_new != key_state);
    rising = commit ? (snap_new & ~key_state) : 16'h0000;
  end

  // Serializer: move the lowest pending key into the FIFO when there is room
  always_comb begin
    pop      = key_ready && (count != '0);
    push     = (pending != 16'h0000) && ((count < CNT_W'(FIFO_DEPTH)) || pop);
    push_idx = 4'h0;
    clr      = 16'h0000;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) push_idx = 4'(i);
    end
    if (push) clr[push_idx] = 1'b1;
    pending_next = (pending & ~clr) | rising;
  end

  // FIFO pointer/count update and next head value
  always_comb begin
    wr_ptr_next = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_next  = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
    code_next = key_code;
    if (count_next != '0) begin
      // The entry being written this cycle becomes the head when nothing older remains
      if (push && (rd_ptr_next == wr_ptr)) code_next = push_idx;
      else                                 code_next = mem[rd_ptr_next];
    end
  end

  // Scanner, debounce and FIFO control registers
  always_ff @(posedge clk) begin
    if (RST) begin
      col_s1     <= 4'hF;
      col_s2     <= 4'hF;
      slot       <= '0;
      row        <= 2'd0;
      row_o      <= 4'b1110;
      snapshot   <= 16'h0000;
      prev_snap  <= 16'h0000;
      scanned    <= 1'b0;
      stable_cnt <= '0;
      key_state  <= 16'h0000;
      pending    <= 16'h0000;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      key_valid  <= 1'b0;
      key_code   <= 4'h0;
    end else begin
      col_s1     <= col_i;
      col_s2     <= col_s1;
      slot       <= slot_end ? '0 : slot + SLOT_W'(1);
      row        <= row_next;
      row_o      <= ~(4'b0001 << row_next);
      snapshot   <= snap_new;
      stable_cnt <= stable_new;
      if (scan_end) begin
        prev_snap <= snap_new;
        scanned   <= 1'b1;
      end
      if (commit) key_state <= snap_new;
      pending    <= pending_next;
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      count      <= count_next;
      key_valid  <= (count_next != '0);
      key_code   <= code_next;
    end
  end

  // FIFO storage (no reset needed, guarded by count)
  always_ff @(posedge clk) begin
    if (!RST && push) mem[wr_ptr] <= push_idx;
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized and directed bench for keypad_scan against a
// scan-level reference model (image history, pending set, event queue).
module tb_keypad_scan;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 2;
  localparam int unsigned DEPTH    = 4;
  localparam int          SCAN_CYC = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        RST;
  logic        key_ready;
  logic [3:0]  row_o;
  logic [3:0]  col_i;
  logic [15:0] key_state;
  logic        key_valid;
  logic [3:0]  key_code;

  logic [15:0] keys;
  int          checks = 0;
  int          errors = 0;

  // Reference model state
  logic [15:0] m_state;
  logic [15:0] m_pending;
  logic [15:0] m_hist[$];
  int          m_q[$];

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .RST(RST),
    .row_o(row_o),
    .col_i(col_i),
    .key_state(key_state),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ready(key_ready)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_o[r] === 1'b0 && keys[r*4+c]) col_i[c] = 1'b0;
  end

  // Run-time watchdog
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_state   = 16'h0000;
    m_pending = 16'h0000;
    m_hist.delete();
    m_q.delete();
  endtask

  // Queue pending keys, lowest index first, while the FIFO has room
  task automatic m_drain();
    while (m_pending != 16'h0000 && m_q.size() < int'(DEPTH)) begin
      for (int i = 0; i < 16; i++) begin
        if (m_pending[i]) begin
          m_q.push_back(i);
          m_pending[i] = 1'b0;
          break;
        end
      end
    end
  endtask

  // A scan image is accepted once the last DEB scans since reset all match it
  task automatic m_scan_end(input logic [15:0] img);
    bit stable;
    m_hist.push_back(img);
    if (m_hist.size() > int'(DEB)) void'(m_hist.pop_front());
    stable = (m_hist.size() == int'(DEB));
    foreach (m_hist[i]) if (m_hist[i] != img) stable = 0;
    if (stable && img != m_state) begin
      m_pending = m_pending | (img & ~m_state);
      m_state   = img;
    end
    m_drain();
  endtask

  // One full scan with a fixed key image; optional pop mid-scan
  task automatic run_scan(input logic [15:0] img, input bit do_pop);
    logic [3:0] er;
    keys = img;
    for (int c = 0; c < SCAN_CYC; c++) begin
      er = 4'hF;
      er[c / SCAN_DIV] = 1'b0;
      check("row_o", 32'(row_o), 32'(er));
      if (c == 5) begin
        check("key_state", 32'(key_state), 32'(m_state));
        check("key_valid", 32'(key_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("key_code", 32'(key_code), 32'(m_q[0]));
        if (do_pop) begin
          key_ready = 1'b1;
          if (m_q.size() != 0) void'(m_q.pop_front());
          m_drain();
        end
      end
      if (c == 6) key_ready = 1'b0;
      tick();
    end
    m_scan_end(img);
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    key_ready = 1'b0;
    repeat (n) tick();
    check("rst_row_o", 32'(row_o), 32'h0000000E);
    check("rst_key_state", 32'(key_state), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_code", 32'(key_code), 32'h0);
    RST = 1'b0;
    m_reset();
  endtask

  task automatic press_release(input int k);
    logic [15:0] img;
    img = 16'h0000;
    img[k] = 1'b1;
    run_scan(img, 1'b0);
    run_scan(img, 1'b0);
    run_scan(16'h0000, 1'b0);
    run_scan(16'h0000, 1'b0);
  endtask

  initial begin
    logic [15:0] img;
    int          exp_codes[5];
    keys      = 16'h0000;
    key_ready = 1'b0;
    m_reset();

    // Reset and row sequencing
    do_reset(3);
    run_scan(16'h0000, 1'b0);
    run_scan(16'h0000, 1'b0);

    // Single press of key 6 held for 5 scans, popped once, then released
    run_scan(16'h0040, 1'b0);
    run_scan(16'h0040, 1'b0);
    check("k6_state", 32'(key_state), 32'h0040);
    run_scan(16'h0040, 1'b0);
    check("k6_code", 32'(key_code), 32'd6);
    run_scan(16'h0040, 1'b1);
    run_scan(16'h0040, 1'b0);
    check("k6_no_repeat", 32'(key_valid), 32'h0);
    repeat (3) run_scan(16'h0000, 1'b0);
    check("k6_release", 32'(key_state), 32'h0);

    // Bounce: toggling every scan never debounces
    for (int s = 0; s < 6; s++) run_scan((s % 2 == 0) ? 16'h0040 : 16'h0000, 1'b0);
    check("bounce_state", 32'(key_state), 32'h0);
    check("bounce_valid", 32'(key_valid), 32'h0);
    repeat (2) run_scan(16'h0000, 1'b0);

    // Simultaneous press of keys 15 and 0
    run_scan(16'h8001, 1'b0);
    run_scan(16'h8001, 1'b0);
    check("simul_state", 32'(key_state), 32'h8001);
    run_scan(16'h8001, 1'b0);
    check("simul_first", 32'(key_code), 32'd0);
    run_scan(16'h0000, 1'b1);
    check("simul_second", 32'(key_code), 32'd15);
    run_scan(16'h0000, 1'b1);
    run_scan(16'h0000, 1'b0);
    check("simul_empty", 32'(key_valid), 32'h0);

    // Overflow: five presses into a four-entry queue
    for (int k = 1; k <= 5; k++) press_release(k);
    exp_codes = '{1, 2, 3, 4, 5};
    for (int i = 0; i < 5; i++) begin
      check("ovf_valid", 32'(key_valid), 32'h1);
      check("ovf_code", 32'(key_code), 32'(exp_codes[i]));
      run_scan(16'h0000, 1'b1);
    end
    run_scan(16'h0000, 1'b0);
    check("ovf_empty", 32'(key_valid), 32'h0);

    // Reset mid-queue with key 9 held
    for (int k = 10; k <= 12; k++) press_release(k);
    run_scan(16'h0200, 1'b0);
    run_scan(16'h0200, 1'b0);
    do_reset(1);
    repeat (4) run_scan(16'h0200, 1'b0);
    check("rq_state", 32'(key_state), 32'h0200);
    check("rq_code", 32'(key_code), 32'd9);
    run_scan(16'h0200, 1'b1);
    run_scan(16'h0200, 1'b0);
    check("rq_once", 32'(key_valid), 32'h0);
    repeat (2) run_scan(16'h0000, 1'b0);

    // Randomized key images and pops, with occasional resets
    img = 16'h0000;
    for (int s = 0; s < 90; s++) begin
      if ($urandom_range(0, 1) == 1) begin
        img = 16'h0000;
        repeat ($urandom_range(0, 3)) img[$urandom_range(0, 15)] = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) do_reset(1);
      run_scan(img, $urandom_range(0, 9) < 4);
    end

    // Drain everything left
    for (int s = 0; s < 24; s++) run_scan(16'h0000, 1'b1);
    run_scan(16'h0000, 1'b0);
    check("final_empty", 32'(key_valid), 32'h0);
    check("final_state", 32'(key_state), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
